// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one pipeline stage carrying an opaque DATA_W-bit payload.
// It uses a valid/ready handshake and a 2-entry skid buffer (main + skid
// register). in_ready is decoded from the state flop, so there is no
// combinational path from out_ready to in_ready.
// Optional build macro PIPE_STAGE_PERF_EN enables the saturating backpressure
// counter on stall_cnt. Without it, stall_cnt is tied to zero.
module pipe_stage_skid #(
    parameter int                 DATA_W        = 64,
    parameter logic [DATA_W-1:0]  RESET_DATA    = '0,
    parameter bit                 ZERO_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [31:0]       stall_cnt
);

    // EMPTY: no entries; BUSY: main only; FULL: main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire;
    logic              out_fire;

    // Outputs are flop outputs or decodes of the state flop only.
    assign out_valid = (state_q == BUSY) || (state_q == FULL);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_data_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Occupancy decode: the state encoding already equals the entry count.
    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // State register and payload registers; reset discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= RESET_DATA;
            skid_data_q <= RESET_DATA;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Next-state and data steering. A flush overrides every handshake.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = EMPTY;
            if (ZERO_ON_FLUSH) begin
                main_data_d = RESET_DATA;
                skid_data_d = RESET_DATA;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = BUSY;
                        main_data_d = in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        state_d     = FULL;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        state_d     = BUSY;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean empty stage.
                    state_d = EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a valid payload is held back by downstream.
    // The count saturates at the maximum value and ignores flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid. It runs directed vectors, hand-written
// corner sequences, and a randomized handshake run. The random run is checked
// against a depth-2 FIFO queue model.
module tb_pipe_stage_skid;

    localparam int              DW      = 16;
    localparam logic [DW-1:0]   RST_VAL = 16'h5A5A;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit              PERF    = 1'b1;
`else
    localparam bit              PERF    = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .DATA_W        (DW),
        .RESET_DATA    (RST_VAL),
        .ZERO_ON_FLUSH (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, then let one clock edge pass and sample 1 time unit later.
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          e_ov;
        logic          e_ir;
        logic [1:0]    e_occ;
        logic          chk_d;
        logic [DW-1:0] e_od;
    } vec_t;

    vec_t vecs[14];

    // Random-run model state.
    logic [DW-1:0] q[$];
    int            nxt;
    int            exp_out;
    longint        stall_m;
    logic [DW-1:0] prev_od;
    bit            prev_stalled;
    bit            r_iv, r_ordy, r_fl, inf, outf, stalled;

    initial begin
        //                iv    id       ordy  fl    ov    ir    occ   chk_d od
        vecs[0]  = '{1'b1, 16'h0011, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 16'h0011};
        vecs[1]  = '{1'b1, 16'h0022, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 16'h0022};
        vecs[2]  = '{1'b1, 16'h0033, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 16'h0033};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 16'h00A1};
        vecs[5]  = '{1'b1, 16'h00A2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 16'h00A1};
        vecs[6]  = '{1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 16'h00A1};
        vecs[7]  = '{1'b1, 16'h00A3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 16'h00A2};
        vecs[8]  = '{1'b1, 16'h00A3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 16'h00A3};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 16'h00B1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 16'h00B1};
        vecs[11] = '{1'b1, 16'h00B2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 16'h00B1};
        vecs[12] = '{1'b1, 16'h00B3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, RST_VAL};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, RST_VAL};

        // Reset state, sampled while rst_n is still low.
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'(RST_VAL));
        chk("rst_stall_cnt", stall_cnt,      32'd0);
        rst_n = 1'b1;

        // Directed vectors: pass-through, backpressure fill, flush while full.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
            if (vecs[i].chk_d)
                chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            $display("vec %0d: iv=%0b id=%0h ordy=%0b fl=%0b -> ov=%0b ir=%0b occ=%0d od=%0h",
                     i, vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl,
                     out_valid, in_ready, occupancy, out_data);
        end

        // Stall counter: seven held cycles, then a flush that must not clear it.
        pulse_reset();
        step(1'b1, 16'h00D1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("perf_stall_7", stall_cnt, PERF ? 32'd7 : 32'd0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("perf_flush_keeps", stall_cnt, PERF ? 32'd7 : 32'd0);
        chk("perf_flush_occ", 32'(occupancy), 32'd0);
        $display("perf: stall_cnt=%0d after hold and flush", stall_cnt);

        // Asynchronous reset between clock edges while BUSY.
        step(1'b1, 16'h00C1, 1'b0, 1'b0);
        chk("async_pre_data", 32'(out_data), 32'h00C1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready",  32'(in_ready),  32'd1);
        chk("async_occupancy", 32'(occupancy), 32'd0);
        chk("async_out_data",  32'(out_data),  32'(RST_VAL));
        chk("async_stall_cnt", stall_cnt,      32'd0);
        #1;
        rst_n = 1'b1;
        step(1'b1, 16'h00C2, 1'b0, 1'b0);
        chk("async_after_data",  32'(out_data),  32'h00C2);
        chk("async_after_valid", 32'(out_valid), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("async_drained", 32'(out_valid), 32'd0);
        $display("async reset: resumed with 00C2 and drained");

        // Randomized handshake against a depth-2 FIFO queue model.
        pulse_reset();
        q.delete();
        nxt = 1;
        exp_out = 1;
        stall_m = 0;
        prev_stalled = 1'b0;
        prev_od = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            r_iv   = ($urandom_range(0, 3) != 0);
            r_ordy = ($urandom_range(0, 2) != 0);
            r_fl   = ($urandom_range(0, 199) == 0);
            in_valid  = r_iv;
            in_data   = DW'(nxt);
            out_ready = r_ordy;
            flush     = r_fl;

            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_in_ready",  32'(in_ready),  32'(q.size() < 2));
            chk("rnd_occupancy", 32'(occupancy), 32'(q.size()));
            chk("rnd_ready_when_full", 32'(in_ready && occupancy == 2'd2), 32'd0);
            if (q.size() > 0) chk("rnd_out_data", 32'(out_data), 32'(q[0]));
            if (prev_stalled) chk("rnd_stable", 32'(out_data), 32'(prev_od));
            chk("rnd_stall_cnt", stall_cnt, PERF ? 32'(stall_m) : 32'd0);

            inf     = r_iv && (q.size() < 2);
            outf    = (q.size() > 0) && r_ordy;
            stalled = (q.size() > 0) && !r_ordy;

            if (outf && !r_fl) begin
                chk("rnd_order", 32'(out_data), 32'(DW'(exp_out)));
                exp_out++;
            end
            if (r_fl) begin
                q.delete();
                exp_out = nxt;
            end else begin
                if (outf) void'(q.pop_front());
                if (inf) begin
                    q.push_back(DW'(nxt));
                    nxt++;
                end
            end
            if (stalled && stall_m < 64'hFFFF_FFFF) stall_m++;
            prev_stalled = stalled && !r_fl;
            prev_od = out_data;

            @(posedge clk);
            #1;
        end
        $display("random: %0d payloads accepted, %0d delivered in order", nxt - 1, exp_out - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID … MEM/WB).
- Carries one opaque DATA_W-bit payload per transfer; the enclosing stage packs pc/inst/decode/except fields into it.
- Replaces the global stall wire with a valid/ready handshake and a 2-entry skid buffer, so in_ready is a registered signal with no combinational path from out_ready.
- Keeps synchronous flush, and adds occupancy reporting.

Parameters:
- DATA_W, 64, payload width in bits (≥1).
- RESET_DATA, 0, value loaded into both data registers on reset.
- ZERO_ON_FLUSH, 1, 1: flush also reloads RESET_DATA into both data registers; 0: flush clears valids only and leaves data as is.

Ports:
- clk  in  1  clock, posedge.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous flush; highest priority after reset.
- in_valid  in  1  upstream holds a valid payload.
- in_ready  out  1  stage can accept a payload; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is valid; registered.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  DATA_W  payload presented downstream; registered.
- occupancy  out  2  number of held entries, 0..2.
- stall_cnt  out  32  backpressure cycle counter (see Optional Feature).

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (main_v, main_d) drives out_valid/out_data. Skid register (skid_v, skid_d). in_ready = ~skid_v.
- State encoding: EMPTY (main_v=0, skid_v=0), BUSY (1,0), FULL (1,1). Occupancy 0/1/2 respectively. The combination main_v=0, skid_v=1 is illegal and never reached.
- Reset, asynchronous on rst_n low:
  - state EMPTY;
  - out_valid=0, in_ready=1, occupancy=0;
  - main_d and skid_d = RESET_DATA;
  - stall_cnt=0.
  - Reset asserted mid-transfer discards both entries; no partial state survives.
- Flush, sync, when rst_n high:
  - next state EMPTY, regardless of in_valid/out_ready that cycle;
  - an in_fire in the flush cycle is dropped;
  - data regs per ZERO_ON_FLUSH;
  - stall_cnt unaffected.
- Transitions when not flushing:
  - EMPTY: in_fire → BUSY, main_d<=in_data. Otherwise stay.
  - BUSY:
    - in_fire & out_fire → BUSY, main_d<=in_data (full throughput).
    - in_fire & ~out_fire → FULL, skid_d<=in_data.
    - ~in_fire & out_fire → EMPTY.
    - neither → stay.
  - FULL: in_ready=0, so in_fire is impossible. out_fire → BUSY, main_d<=skid_d, skid_v<=0. Otherwise stay.
- Latency: in_fire at cycle N → out_valid and out_data visible at cycle N+1 when entering from EMPTY. Steady-state throughput is 1 transfer/cycle.
- Ordering: strict FIFO; payloads are never reordered or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data holds constant.
- Upstream rule: upstream may drop in_valid at any time. The stage never requires in_data to remain stable after in_fire.
- No combinational path from any input to any output. All outputs are flop outputs or decodes of flops (occupancy).

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments by 1 on every cycle with out_valid=1 & out_ready=0;
  - saturates at 32'hFFFF_FFFF;
  - clears only on reset (not on flush).
- Undefined: counter logic absent; stall_cnt tied to 32'h0. The port list is identical in both builds.

Test Plan:
- Reset then pass-through:
  - rst_n=0 → out_valid=0, in_ready=1, occupancy=0, out_data=RESET_DATA.
  - Release reset, out_ready=1, drive in_data=0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 on the following three cycles, one per cycle.
- Backpressure fill:
  - out_ready=0, push 0xA1 then 0xA2 → occupancy=2, in_ready=0, out_data=0xA1 held.
  - A third push 0xA3 is not accepted.
  - Raise out_ready → outputs 0xA1, 0xA2, then 0xA3 after re-acceptance; no loss or duplication.
- Flush while FULL:
  - FULL with 0xB1/0xB2, assert flush for 1 cycle with in_valid=1, in_data=0xB3 → next cycle occupancy=0, out_valid=0, in_ready=1.
  - 0xB3 never appears.
  - With ZERO_ON_FLUSH=1, out_data=RESET_DATA.
- Async reset mid-operation:
  - In BUSY with out_data=0xC1, pulse rst_n low between clock edges → out_valid drops immediately, before the next clk edge.
  - After release the stage accepts 0xC2 normally.
- Random handshake:
  - 10,000 cycles of random in_valid/out_ready with incrementing payloads → scoreboard shows an in-order, lossless sequence.
  - in_ready is never 1 while occupancy=2.
  - out_data is stable across every stalled cycle.
- PIPE_STAGE_PERF_EN:
  - Hold out_valid=1, out_ready=0 for 7 cycles → stall_cnt=7.
  - A flush leaves stall_cnt=7.
  - With the macro undefined, stall_cnt=0 throughout.
